// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave front-end for a single-port 2^ADDR_W x 32 SRAM, zero wait states via a one-entry write buffer.
// Optional macro AHB_SRAM_ERR_EN: reject misaligned or oversized transfers with a two-cycle ERROR response.
module ahb_sram_ctrl #(
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic [31:0]       SRAM_D,
  output logic              SRAM_CEN,
  output logic              SRAM_WEN,
  output logic [3:0]        SRAM_BWEN,
  input  logic [31:0]       SRAM_Q
);

  logic              acc;
  logic              illegal;
  logic              rd_ap;
  logic              wr_ap;
  logic [3:0]        strb;
  logic [ADDR_W-1:0] ap_addr;
  logic              hreadyout;
  logic              hresp;
  logic              fwd_hit;
  logic [31:0]       hrdata;

  logic              rd_dp_q, rd_dp_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_dp_q, wr_dp_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]        wr_strb_q, wr_strb_d;
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [3:0]        buf_strb_q, buf_strb_d;
  logic [31:0]       buf_data_q, buf_data_d;
  logic [ADDR_W-1:0] sram_a_q, sram_a_d;
  logic [31:0]       sram_d_q, sram_d_d;
  logic              sram_cen_d;
  logic              sram_wen_d;
  logic [3:0]        sram_bwen_d;

  logic              unused_bits;
  assign unused_bits = ^{HADDR[31:ADDR_W+2], HTRANS[0]};

  assign acc     = HSEL & HREADY & HTRANS[1];
  assign rd_ap   = acc & ~HWRITE & ~illegal;
  assign wr_ap   = acc & HWRITE & ~illegal;
  assign ap_addr = HADDR[ADDR_W+1:2];

  always_comb begin
    strb = 4'b1111;
    case (HSIZE)
      3'd0:    strb = 4'b0001 << HADDR[1:0];
      3'd1:    strb = HADDR[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

`ifdef AHB_SRAM_ERR_EN
  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} err_state_t;
  err_state_t state_q, state_d;

  always_comb begin
    illegal = 1'b0;
    if (HSIZE > 3'd2)       illegal = 1'b1;
    else if (HSIZE == 3'd1) illegal = HADDR[0];
    else if (HSIZE == 3'd2) illegal = |HADDR[1:0];
  end

  always_comb begin
    state_d   = state_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc && illegal) state_d = ST_ERR1;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        hresp   = 1'b1;
        state_d = (acc && illegal) ? ST_ERR1 : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end
`else
  assign illegal   = 1'b0;
  assign hreadyout = 1'b1;
  assign hresp     = 1'b0;
`endif

  // Reads own the port in their address phase; a colliding write data phase is parked in the buffer.
  always_comb begin
    rd_dp_d     = rd_ap;
    rd_addr_d   = rd_ap ? ap_addr : rd_addr_q;
    wr_dp_d     = wr_ap;
    wr_addr_d   = wr_ap ? ap_addr : wr_addr_q;
    wr_strb_d   = wr_ap ? strb : wr_strb_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_strb_d  = buf_strb_q;
    buf_data_d  = buf_data_q;
    sram_cen_d  = 1'b1;
    sram_wen_d  = 1'b1;
    sram_bwen_d = 4'b1111;
    sram_a_d    = sram_a_q;
    sram_d_d    = sram_d_q;
    if (rd_ap) begin
      sram_cen_d = 1'b0;
      sram_a_d   = ap_addr;
      if (wr_dp_q) begin
        buf_valid_d = 1'b1;
        buf_addr_d  = wr_addr_q;
        buf_strb_d  = wr_strb_q;
        buf_data_d  = HWDATA;
      end
    end else if (wr_dp_q) begin
      sram_cen_d  = 1'b0;
      sram_wen_d  = 1'b0;
      sram_a_d    = wr_addr_q;
      sram_d_d    = HWDATA;
      sram_bwen_d = ~wr_strb_q;
    end else if (buf_valid_q) begin
      sram_cen_d  = 1'b0;
      sram_wen_d  = 1'b0;
      sram_a_d    = buf_addr_q;
      sram_d_d    = buf_data_q;
      sram_bwen_d = ~buf_strb_q;
      buf_valid_d = 1'b0;
    end
    // Reset suppresses any access in the same cycle, including a pending buffer flush.
    if (RST) begin
      sram_cen_d  = 1'b1;
      sram_wen_d  = 1'b1;
      sram_bwen_d = 4'b1111;
      sram_a_d    = '0;
      sram_d_d    = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_dp_q     <= 1'b0;
      rd_addr_q   <= '0;
      wr_dp_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_strb_q   <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_strb_q  <= '0;
      buf_data_q  <= '0;
      sram_a_q    <= '0;
      sram_d_q    <= '0;
    end else begin
      rd_dp_q     <= rd_dp_d;
      rd_addr_q   <= rd_addr_d;
      wr_dp_q     <= wr_dp_d;
      wr_addr_q   <= wr_addr_d;
      wr_strb_q   <= wr_strb_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_strb_q  <= buf_strb_d;
      buf_data_q  <= buf_data_d;
      sram_a_q    <= sram_a_d;
      sram_d_q    <= sram_d_d;
    end
  end

  assign fwd_hit = buf_valid_q && (buf_addr_q == rd_addr_q);

  // Buffered bytes are newer than the SRAM contents, even in the cycle they are being flushed.
  always_comb begin
    hrdata = '0;
    if (rd_dp_q && !RST) begin
      for (int n = 0; n < 4; n++) begin
        hrdata[8*n +: 8] = (fwd_hit && buf_strb_q[n]) ? buf_data_q[8*n +: 8] : SRAM_Q[8*n +: 8];
      end
    end
  end

  assign HRDATA    = hrdata;
  assign HREADYOUT = hreadyout | RST;
  assign HRESP     = hresp & ~RST;
  assign SRAM_A    = sram_a_d;
  assign SRAM_D    = sram_d_d;
  assign SRAM_CEN  = sram_cen_d;
  assign SRAM_WEN  = sram_wen_d;
  assign SRAM_BWEN = sram_bwen_d;

  no_wr_dp_with_buf: assert property (@(posedge CLK) disable iff (RST) !(wr_dp_q && buf_valid_q));

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Directed, table-driven bench for ahb_sram_ctrl with a behavioural 64K x 32 SRAM model.
module tb_ahb_sram_ctrl;

  localparam int ADDR_W = 16;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] ID = 2'b00;

  logic              CLK = 1'b0;
  logic              RST;
  logic              HSEL;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic [31:0]       HRDATA;
  logic              HREADYOUT;
  logic              HRESP;
  logic [ADDR_W-1:0] SRAM_A;
  logic [31:0]       SRAM_D;
  logic              SRAM_CEN;
  logic              SRAM_WEN;
  logic [3:0]        SRAM_BWEN;
  logic [31:0]       SRAM_Q;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  ahb_sram_ctrl #(.ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .SRAM_A(SRAM_A), .SRAM_D(SRAM_D), .SRAM_CEN(SRAM_CEN), .SRAM_WEN(SRAM_WEN),
    .SRAM_BWEN(SRAM_BWEN), .SRAM_Q(SRAM_Q)
  );

  // Behavioural SRAM: byte-masked writes, read data registered one cycle after the command.
  bit [31:0] mem [0:(1<<ADDR_W)-1];
  bit [31:0] sram_q;
  assign SRAM_Q = sram_q;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] bwen);
    merge = old;
    for (int n = 0; n < 4; n++) if (!bwen[n]) merge[8*n +: 8] = d[8*n +: 8];
  endfunction

  always @(posedge CLK) begin
    if (SRAM_CEN == 1'b0) begin
      if (SRAM_WEN == 1'b0) mem[SRAM_A] <= merge(mem[SRAM_A], SRAM_D, SRAM_BWEN);
      else                  sram_q <= mem[SRAM_A];
    end
  end

  typedef struct {
    logic        sel;
    logic        ready;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_cen;
    logic        exp_wen;
    logic [3:0]  exp_bwen;
    logic [15:0] exp_a;
    logic [31:0] exp_d;
    logic [31:0] exp_rdata;
    logic        exp_hready;
    logic        exp_hresp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t bus(input logic [1:0] trans, input logic write, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata);
    vec_t r;
    r.sel = 1'b1; r.ready = 1'b1; r.trans = trans; r.write = write; r.size = size;
    r.addr = addr; r.wdata = wdata;
    r.exp_cen = 1'b1; r.exp_wen = 1'b1; r.exp_bwen = 4'hF; r.exp_a = '0; r.exp_d = '0;
    r.exp_rdata = '0; r.exp_hready = 1'b1; r.exp_hresp = 1'b0;
    return r;
  endfunction

  function automatic vec_t ctl(input vec_t v, input logic sel, input logic ready);
    vec_t r = v;
    r.sel = sel; r.ready = ready;
    return r;
  endfunction

  function automatic vec_t srd(input vec_t v, input logic [15:0] a);
    vec_t r = v;
    r.exp_cen = 1'b0; r.exp_wen = 1'b1; r.exp_bwen = 4'hF; r.exp_a = a;
    return r;
  endfunction

  function automatic vec_t swr(input vec_t v, input logic [15:0] a, input logic [31:0] d, input logic [3:0] bwen);
    vec_t r = v;
    r.exp_cen = 1'b0; r.exp_wen = 1'b0; r.exp_bwen = bwen; r.exp_a = a; r.exp_d = d;
    return r;
  endfunction

  function automatic vec_t rdv(input vec_t v, input logic [31:0] data);
    vec_t r = v;
    r.exp_rdata = data;
    return r;
  endfunction

  function automatic vec_t rsp(input vec_t v, input logic hready, input logic hresp);
    vec_t r = v;
    r.exp_hready = hready; r.exp_hresp = hresp;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v);
    HSEL   = v.sel;
    HREADY = v.ready;
    HTRANS = v.trans;
    HWRITE = v.write;
    HSIZE  = v.size;
    HADDR  = v.addr;
    HWDATA = v.wdata;
  endtask

  task automatic checkOutput(input string tag, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s step %0d: got %h, expected %h", tag, idx, act, exp);
    end
  endtask

  task automatic checkVector(input vec_t v, input int idx);
    checkOutput("hreadyout", idx, {31'b0, HREADYOUT}, {31'b0, v.exp_hready});
    checkOutput("hresp", idx, {31'b0, HRESP}, {31'b0, v.exp_hresp});
    checkOutput("cen", idx, {31'b0, SRAM_CEN}, {31'b0, v.exp_cen});
    checkOutput("hrdata", idx, HRDATA, v.exp_rdata);
    if (v.exp_cen == 1'b0) begin
      checkOutput("wen", idx, {31'b0, SRAM_WEN}, {31'b0, v.exp_wen});
      checkOutput("addr", idx, {16'b0, SRAM_A}, {16'b0, v.exp_a});
      checkOutput("bwen", idx, {28'b0, SRAM_BWEN}, {28'b0, v.exp_bwen});
      if (v.exp_wen == 1'b0) checkOutput("wdata", idx, SRAM_D, v.exp_d);
    end
  endtask

  task automatic stepVec(input vec_t v, input int idx, input logic rst);
    @(posedge CLK);
    #1;
    RST = rst;
    applyStimulus(v);
    @(negedge CLK);
    checkVector(v, idx);
  endtask

  initial begin
    RST = 1'b1;
    applyStimulus(bus(ID, 1'b0, 3'd2, 32'h0, 32'h0));

    // Reset state, both while held and just after release.
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_cen", 0, {31'b0, SRAM_CEN}, 32'd1);
    checkOutput("rst_wen", 0, {31'b0, SRAM_WEN}, 32'd1);
    checkOutput("rst_bwen", 0, {28'b0, SRAM_BWEN}, 32'hF);
    checkOutput("rst_hreadyout", 0, {31'b0, HREADYOUT}, 32'd1);
    checkOutput("rst_hresp", 0, {31'b0, HRESP}, 32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    checkOutput("rst_a", 1, {16'b0, SRAM_A}, 32'd0);
    checkOutput("rst_d", 1, SRAM_D, 32'd0);
    checkOutput("rst_hrdata", 1, HRDATA, 32'd0);
    checkOutput("rst_cen2", 1, {31'b0, SRAM_CEN}, 32'd1);

    // Direct write, idle, read back
    vecs.push_back(bus(NS, 1'b1, 3'd2, 32'h0000_0100, 32'h0));
    vecs.push_back(swr(bus(ID, 1'b0, 3'd2, 32'h0, 32'hDEADBEEF), 16'h0040, 32'hDEADBEEF, 4'b0000));
    vecs.push_back(bus(ID, 1'b0, 3'd2, 32'h0, 32'h0));
    vecs.push_back(srd(bus(NS, 1'b0, 3'd2, 32'h0000_0100, 32'h0), 16'h0040));
    vecs.push_back(rdv(bus(ID, 1'b0, 3'd2, 32'h0, 32'h0), 32'hDEADBEEF));
    // Write then immediate read: buffered, forwarded, flushed, read back from SRAM
    vecs.push_back(bus(NS, 1'b1, 3'd2, 32'h0000_0020, 32'h0));
    vecs.push_back(srd(bus(NS, 1'b0, 3'd2, 32'h0000_0020, 32'h11223344), 16'h0008));
    vecs.push_back(rdv(swr(bus(ID, 1'b0, 3'd2, 32'h0, 32'h0), 16'h0008, 32'h11223344, 4'b0000), 32'h11223344));
    vecs.push_back(bus(ID, 1'b0, 3'd2, 32'h0, 32'h0));
    vecs.push_back(srd(bus(NS, 1'b0, 3'd2, 32'h0000_0020, 32'h0), 16'h0008));
    vecs.push_back(rdv(bus(ID, 1'b0, 3'd2, 32'h0, 32'h0), 32'h11223344));
    // Word write, byte write into lane 2, back-to-back read with partial forwarding
    vecs.push_back(bus(NS, 1'b1, 3'd2, 32'h0000_0040, 32'h0));
    vecs.push_back(swr(bus(NS, 1'b1, 3'd0, 32'h0000_0042, 32'hAABBCCDD), 16'h0010, 32'hAABBCCDD, 4'b0000));
    vecs.push_back(srd(bus(NS, 1'b0, 3'd2, 32'h0000_0040, 32'h0055_0000), 16'h0010));
    vecs.push_back(rdv(swr(bus(ID, 1'b0, 3'd2, 32'h0, 32'h0), 16'h0010, 32'h0055_0000, 4'b1011), 32'hAA55CCDD));
    vecs.push_back(srd(bus(NS, 1'b0, 3'd2, 32'h0000_0040, 32'h0), 16'h0010));
    vecs.push_back(rdv(bus(ID, 1'b0, 3'd2, 32'h0, 32'h0), 32'hAA55CCDD));
    // Last word of each bank and the wrap past the window
    vecs.push_back(bus(NS, 1'b1, 3'd2, 32'h0000_FFFC, 32'h0));
    vecs.push_back(swr(bus(NS, 1'b1, 3'd2, 32'h0001_FFFC, 32'd1), 16'h3FFF, 32'd1, 4'b0000));
    vecs.push_back(swr(bus(NS, 1'b1, 3'd2, 32'h0002_FFFC, 32'd2), 16'h7FFF, 32'd2, 4'b0000));
    vecs.push_back(swr(bus(NS, 1'b1, 3'd2, 32'h0003_FFFC, 32'd3), 16'hBFFF, 32'd3, 4'b0000));
    vecs.push_back(swr(bus(NS, 1'b1, 3'd2, 32'h0004_0000, 32'd4), 16'hFFFF, 32'd4, 4'b0000));
    vecs.push_back(swr(bus(ID, 1'b0, 3'd2, 32'h0, 32'd5), 16'h0000, 32'd5, 4'b0000));
    vecs.push_back(srd(bus(NS, 1'b0, 3'd2, 32'h0000_0000, 32'h0), 16'h0000));
    vecs.push_back(rdv(srd(bus(NS, 1'b0, 3'd2, 32'h0003_FFFC, 32'h0), 16'hFFFF), 32'd5));
    vecs.push_back(rdv(bus(ID, 1'b0, 3'd2, 32'h0, 32'h0), 32'd4));
    // Upper half-word write
    vecs.push_back(bus(NS, 1'b1, 3'd1, 32'h0000_0102, 32'h0));
    vecs.push_back(swr(bus(ID, 1'b0, 3'd2, 32'h0, 32'h1234_0000), 16'h0040, 32'h1234_0000, 4'b0011));
    vecs.push_back(srd(bus(NS, 1'b0, 3'd2, 32'h0000_0100, 32'h0), 16'h0040));
    vecs.push_back(rdv(bus(ID, 1'b0, 3'd2, 32'h0, 32'h0), 32'h1234BEEF));
    // HREADY low and HSEL low: nothing accepted
    vecs.push_back(ctl(bus(NS, 1'b1, 3'd2, 32'h0000_0200, 32'h0), 1'b1, 1'b0));
    vecs.push_back(ctl(bus(NS, 1'b1, 3'd2, 32'h0000_0204, 32'h0), 1'b0, 1'b1));
    // Buffer flush proceeds while another slave holds HREADY low
    vecs.push_back(bus(NS, 1'b1, 3'd2, 32'h0000_0300, 32'h0));
    vecs.push_back(srd(bus(NS, 1'b0, 3'd2, 32'h0000_0300, 32'h0BADF00D), 16'h00C0));
    vecs.push_back(rdv(swr(ctl(bus(NS, 1'b0, 3'd2, 32'h0000_0300, 32'h0), 1'b1, 1'b0),
                           16'h00C0, 32'h0BADF00D, 4'b0000), 32'h0BADF00D));
    vecs.push_back(bus(ID, 1'b0, 3'd2, 32'h0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) stepVec(vecs[i], 10 + i, 1'b0);

    // A buffered write pending at reset must be discarded
    stepVec(bus(NS, 1'b1, 3'd2, 32'h0000_0500, 32'h0), 100, 1'b0);
    stepVec(swr(bus(ID, 1'b0, 3'd2, 32'h0, 32'h0102_0304), 16'h0140, 32'h0102_0304, 4'b0000), 101, 1'b0);
    stepVec(bus(NS, 1'b1, 3'd2, 32'h0000_0500, 32'h0), 102, 1'b0);
    stepVec(srd(bus(NS, 1'b0, 3'd2, 32'h0000_0500, 32'hCAFE_0001), 16'h0140), 103, 1'b0);
    stepVec(bus(ID, 1'b0, 3'd2, 32'h0, 32'h0), 104, 1'b1);
    checkOutput("rstmid_a", 104, {16'b0, SRAM_A}, 32'd0);
    checkOutput("rstmid_d", 104, SRAM_D, 32'd0);
    stepVec(srd(bus(NS, 1'b0, 3'd2, 32'h0000_0500, 32'h0), 16'h0140), 105, 1'b0);
    stepVec(rdv(bus(ID, 1'b0, 3'd2, 32'h0, 32'h0), 32'h0102_0304), 106, 1'b0);

`ifdef AHB_SRAM_ERR_EN
    // Misaligned word read: two-cycle ERROR, no SRAM access
    stepVec(bus(NS, 1'b0, 3'd2, 32'h0000_0002, 32'h0), 200, 1'b0);
    stepVec(rsp(ctl(bus(ID, 1'b0, 3'd2, 32'h0, 32'h0), 1'b1, 1'b0), 1'b0, 1'b1), 201, 1'b0);
    stepVec(rsp(bus(ID, 1'b0, 3'd2, 32'h0, 32'h0), 1'b1, 1'b1), 202, 1'b0);
    stepVec(bus(ID, 1'b0, 3'd2, 32'h0, 32'h0), 203, 1'b0);
`else
    // Misaligned word read falls back to the enclosing word with OKAY
    stepVec(srd(bus(NS, 1'b0, 3'd2, 32'h0000_0002, 32'h0), 16'h0000), 200, 1'b0);
    stepVec(rdv(bus(ID, 1'b0, 3'd2, 32'h0, 32'h0), 32'd5), 201, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ahb_sram_ctrl.md
Name: ahb_sram_ctrl

Overview:
- AHB-Lite slave front-end for the 64K x 32 single-port SRAM macro (256 KB window).
- Converts AHB address/data-phase transfers into single-cycle SRAM commands with active-low CEN/WEN/BWEN.
- Zero-wait-state reads. Writes go through a one-entry write buffer with read-after-write forwarding, so the single port never needs an AHB wait state.

Parameters:
- ADDR_W, 16, SRAM word-address width; the window is 2^(ADDR_W+2) bytes.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address; only [ADDR_W+1:0] is used.
- HTRANS  in  2  transfer type; bit 1 set means NONSEQ/SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus ready.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- SRAM_A  out  ADDR_W  word address.
- SRAM_D  out  32  write data.
- SRAM_CEN  out  1  chip enable, active-low.
- SRAM_WEN  out  1  write enable, active-low.
- SRAM_BWEN  out  4  byte-lane write enable, active-low; bit n covers D[8n+7:8n].
- SRAM_Q  in  32  read data, valid the cycle after a read command.

Behaviour:
- Transfer accept: acc = HSEL & HREADY & HTRANS[1].
  - rd_ap = acc & ~HWRITE.
  - wr_ap = acc & HWRITE.
- Byte strobes strb[3:0]:
  - byte: 1 << HADDR[1:0].
  - half: HADDR[1] ? 1100 : 0011.
  - word: 1111.
- Registered data-phase state, all cleared by RST:
  - rd_dp, plus registered rd_addr.
  - wr_dp, plus registered wr_addr and wr_strb.
  - Write buffer: buf_valid, buf_addr, buf_strb, buf_data.
- SRAM port arbitration per cycle, combinational, priority order:
  1. rd_ap: CEN=0, WEN=1, A=HADDR[ADDR_W+1:2], BWEN=1111.
  2. wr_dp (and not rd_ap): CEN=0, WEN=0, A=wr_addr, D=HWDATA, BWEN=~wr_strb (direct write).
  3. buf_valid (and not rd_ap): CEN=0, WEN=0, A=buf_addr, D=buf_data, BWEN=~buf_strb; buf_valid clears at the clock edge.
  4. Otherwise: CEN=1, WEN=1, BWEN=1111. A and D hold their last values.
- Buffer capture: when wr_dp & rd_ap, load the buffer from {wr_addr, wr_strb, HWDATA} and set buf_valid.
  - Invariant, to be asserted in RTL: wr_dp & buf_valid never both 1. A buffered write always has a non-read cycle before the next write data phase.
- Read data, in the rd_dp cycle:
  - HRDATA = SRAM_Q, with per-lane replacement by buf_data where buf_valid & buf_addr==rd_addr & buf_strb[n].
  - Forwarding still applies in the cycle the buffer is being flushed.
  - HRDATA = 0 when rd_dp=0.
- Read latency: address phase in cycle N, HRDATA valid in cycle N+1. HREADYOUT=1, HRESP=0 except on error.
- Address wraps modulo 2^ADDR_W words; HADDR bits above ADDR_W+1 are ignored.
- Reset values:
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - SRAM_CEN=1, SRAM_WEN=1, SRAM_BWEN=1111.
  - SRAM_A and SRAM_D = 0.
- Reset mid-operation: a pending buffered write is discarded, and no SRAM access occurs in the reset cycle.
- HREADY=0 from another slave: no transfer is accepted, but a buffer flush may still proceed.

Optional Feature:
- Macro: AHB_SRAM_ERR_EN.
- Defined: a transfer is illegal if it is misaligned (half with HADDR[0]=1, or word with HADDR[1:0]≠0) or has HSIZE>2.
  - An illegal transfer produces the two-cycle ERROR response: cycle 1 HREADYOUT=0, HRESP=1; cycle 2 HREADYOUT=1, HRESP=1.
  - No SRAM access and no buffer update occur.
  - Implemented as a state machine IDLE → ERR1 → ERR2 → IDLE.
- Undefined: HSIZE>2 is treated as word, low address bits are ignored for half/word, and HRESP is tied to 0.

Test Plan:
- Word write 0xDEADBEEF @0x0000_0100, IDLE, read @0x100 → SRAM write at A=0x040, BWEN=0000; HRDATA=0xDEADBEEF, zero wait states.
- Write 0x11223344 @0x20 followed immediately by a read @0x20 → write captured into buffer (buf_valid=1); HRDATA=0x11223344 by forwarding; buffer flushed the next non-read cycle.
- Word 0xAABBCCDD @0x40, then byte write 0x55 at 0x42 (HWDATA=0x0055_0000), back-to-back read @0x40 → HRDATA=0xAA55CCDD; SRAM_BWEN=1011 on the byte write.
- Writes to the last word of each 16K bank (HADDR 0xFFFC, 0x1FFFC, 0x2FFFC, 0x3FFFC) and to HADDR 0x40000 → SRAM_A = 0x3FFF, 0x7FFF, 0xBFFF, 0xFFFF, and 0x0000 (wrap).
- Buffered write pending, RST for 1 cycle, read the same address → no SRAM write issued; old data returned.
- With AHB_SRAM_ERR_EN: word read @0x02 → HREADYOUT 0 then 1, HRESP 1 for both cycles, SRAM_CEN stays 1. Without the macro → reads the word @0x00 with OKAY.
